// File: rtl/option_price_sched.sv
// Round-robin scheduler sharing one Black-Scholes OptionPrice datapath among NREQ requesters.
// Latches the winner's operands, pulses op_start, waits with a watchdog and returns a tagged price.
module option_price_sched #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_rate,
    input  logic [NREQ*WIDTH-1:0] req_timetm,
    input  logic [NREQ*WIDTH-1:0] req_spot,
    input  logic [NREQ*WIDTH-1:0] req_strike,
    input  logic [NREQ*WIDTH-1:0] req_nd1,
    input  logic [NREQ*WIDTH-1:0] req_nd2,
    input  logic [NREQ-1:0]       req_otype,
    output logic [WIDTH-1:0]      op_rate,
    output logic [WIDTH-1:0]      op_timetm,
    output logic [WIDTH-1:0]      op_spot,
    output logic [WIDTH-1:0]      op_strike,
    output logic [WIDTH-1:0]      op_nd1,
    output logic [WIDTH-1:0]      op_nd2,
    output logic                  op_otype,
    output logic                  op_start,
    input  logic                  op_done,
    input  logic [WIDTH-1:0]      op_price,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_price,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [WIDTH-1:0]   op_rate_q, op_rate_d, op_timetm_q, op_timetm_d;
    logic [WIDTH-1:0]   op_spot_q, op_spot_d, op_strike_q, op_strike_d;
    logic [WIDTH-1:0]   op_nd1_q, op_nd1_d, op_nd2_q, op_nd2_d;
    logic               op_otype_q, op_otype_d, op_start_q, op_start_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_price_q, rsp_price_d;
    logic               busy_q, busy_d;
    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;

    // Round-robin search from rr_ptr; the accept is combinational and only offered in IDLE.
    always_comb begin
        int unsigned cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
        if (state_q == IDLE && !reset && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        op_rate_d   = op_rate_q;
        op_timetm_d = op_timetm_q;
        op_spot_d   = op_spot_q;
        op_strike_d = op_strike_q;
        op_nd1_d    = op_nd1_q;
        op_nd2_d    = op_nd2_q;
        op_otype_d  = op_otype_q;
        op_start_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_id_d    = rsp_id_q;
        rsp_price_d = rsp_price_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    op_rate_d   = req_rate[32'(grant_idx)*WIDTH +: WIDTH];
                    op_timetm_d = req_timetm[32'(grant_idx)*WIDTH +: WIDTH];
                    op_spot_d   = req_spot[32'(grant_idx)*WIDTH +: WIDTH];
                    op_strike_d = req_strike[32'(grant_idx)*WIDTH +: WIDTH];
                    op_nd1_d    = req_nd1[32'(grant_idx)*WIDTH +: WIDTH];
                    op_nd2_d    = req_nd2[32'(grant_idx)*WIDTH +: WIDTH];
                    op_otype_d  = req_otype[grant_idx];
                    rsp_id_d    = grant_idx;
                    op_start_d  = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // A completion coinciding with expiry still returns the real price.
                if (op_done) begin
                    rsp_price_d = op_price;
                    rsp_error_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_price_d = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            op_rate_q   <= '0;
            op_timetm_q <= '0;
            op_spot_q   <= '0;
            op_strike_q <= '0;
            op_nd1_q    <= '0;
            op_nd2_q    <= '0;
            op_otype_q  <= 1'b0;
            op_start_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_price_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            op_rate_q   <= op_rate_d;
            op_timetm_q <= op_timetm_d;
            op_spot_q   <= op_spot_d;
            op_strike_q <= op_strike_d;
            op_nd1_q    <= op_nd1_d;
            op_nd2_q    <= op_nd2_d;
            op_otype_q  <= op_otype_d;
            op_start_q  <= op_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_id_q    <= rsp_id_d;
            rsp_price_q <= rsp_price_d;
            busy_q      <= busy_d;
        end
    end

    assign op_rate   = op_rate_q;
    assign op_timetm = op_timetm_q;
    assign op_spot   = op_spot_q;
    assign op_strike = op_strike_q;
    assign op_nd1    = op_nd1_q;
    assign op_nd2    = op_nd2_q;
    assign op_otype  = op_otype_q;
    assign op_start  = op_start_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_price = rsp_price_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_option_price_sched.sv
// Bench for option_price_sched: transaction-level scoreboard with a stub datapath.
// Two instances (long and short watchdog); the unused one is held in reset and outputs are muxed.
module tb_option_price_sched;

    localparam int unsigned W = 32, N = 4, IDW = 2, TO_A = 64, TO_W = 16;

    typedef struct packed {
        logic [W-1:0] rate, timetm, spot, strike, nd1, nd2;
        logic         otype;
    } ops_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, sel = 1'b0;
    logic [N-1:0] req_valid = '0, req_otype = '0;
    logic [N*W-1:0] req_rate = '0, req_timetm = '0, req_spot = '0, req_strike = '0, req_nd1 = '0, req_nd2 = '0;
    logic op_done = 1'b0, rsp_ready = 1'b0;
    logic [W-1:0] op_price = '0;
    logic a_reset, w_reset;
    assign a_reset = reset | sel;
    assign w_reset = reset | ~sel;

    logic [N-1:0]   a_req_ready, w_req_ready, m_req_ready;
    logic [W-1:0]   a_op_rate, a_op_timetm, a_op_spot, a_op_strike, a_op_nd1, a_op_nd2, a_rsp_price;
    logic [W-1:0]   w_op_rate, w_op_timetm, w_op_spot, w_op_strike, w_op_nd1, w_op_nd2, w_rsp_price;
    logic [W-1:0]   m_op_rate, m_op_timetm, m_op_spot, m_op_strike, m_op_nd1, m_op_nd2, m_rsp_price;
    logic           a_op_otype, a_op_start, a_rsp_valid, a_rsp_error, a_busy;
    logic           w_op_otype, w_op_start, w_rsp_valid, w_rsp_error, w_busy;
    logic           m_op_otype, m_op_start, m_rsp_valid, m_rsp_error, m_busy;
    logic [IDW-1:0] a_rsp_id, w_rsp_id, m_rsp_id;

    option_price_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(a_reset), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_rate(req_rate), .req_timetm(req_timetm), .req_spot(req_spot), .req_strike(req_strike),
        .req_nd1(req_nd1), .req_nd2(req_nd2), .req_otype(req_otype),
        .op_rate(a_op_rate), .op_timetm(a_op_timetm), .op_spot(a_op_spot), .op_strike(a_op_strike),
        .op_nd1(a_op_nd1), .op_nd2(a_op_nd2), .op_otype(a_op_otype), .op_start(a_op_start),
        .op_done(op_done), .op_price(op_price), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(a_rsp_id), .rsp_price(a_rsp_price), .rsp_error(a_rsp_error), .busy(a_busy));

    option_price_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW), .TIMEOUT(TO_W)) dut_w (
        .clk(clk), .reset(w_reset), .req_valid(req_valid), .req_ready(w_req_ready),
        .req_rate(req_rate), .req_timetm(req_timetm), .req_spot(req_spot), .req_strike(req_strike),
        .req_nd1(req_nd1), .req_nd2(req_nd2), .req_otype(req_otype),
        .op_rate(w_op_rate), .op_timetm(w_op_timetm), .op_spot(w_op_spot), .op_strike(w_op_strike),
        .op_nd1(w_op_nd1), .op_nd2(w_op_nd2), .op_otype(w_op_otype), .op_start(w_op_start),
        .op_done(op_done), .op_price(op_price), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(w_rsp_id), .rsp_price(w_rsp_price), .rsp_error(w_rsp_error), .busy(w_busy));

    assign m_req_ready = sel ? w_req_ready : a_req_ready;
    assign m_op_rate   = sel ? w_op_rate   : a_op_rate;
    assign m_op_timetm = sel ? w_op_timetm : a_op_timetm;
    assign m_op_spot   = sel ? w_op_spot   : a_op_spot;
    assign m_op_strike = sel ? w_op_strike : a_op_strike;
    assign m_op_nd1    = sel ? w_op_nd1    : a_op_nd1;
    assign m_op_nd2    = sel ? w_op_nd2    : a_op_nd2;
    assign m_op_otype  = sel ? w_op_otype  : a_op_otype;
    assign m_op_start  = sel ? w_op_start  : a_op_start;
    assign m_rsp_valid = sel ? w_rsp_valid : a_rsp_valid;
    assign m_rsp_id    = sel ? w_rsp_id    : a_rsp_id;
    assign m_rsp_price = sel ? w_rsp_price : a_rsp_price;
    assign m_rsp_error = sel ? w_rsp_error : a_rsp_error;
    assign m_busy      = sel ? w_busy      : a_busy;

    int checks = 0, fails = 0;
    int cyc = 0;

    // Knobs
    int p_new = 0, p_drop = 0, p_rdy = 100, p_stray = 0, hold_n = 0, lat_mode = -1, price_mode = 0;
    int p_rst = 0, rst_cnt = 3;
    logic [W-1:0] fixed_price = '0;

    // Requester and job model
    ops_t rq [N];
    bit   pend [N];
    bit   job = 0, post_rst = 0;
    int   job_id = 0, acc_cyc = 0, exp_rsp = 0, done_cyc = -1, ptr = 0, rsp_cnt = 0;
    ops_t job_ops;
    logic [W-1:0] exp_price = '0, stub_price = '0;
    bit   exp_err = 0;
    int   grants [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic ops_t rand_ops();
        ops_t o;
        o.rate = $urandom; o.timetm = $urandom; o.spot = $urandom;
        o.strike = $urandom; o.nd1 = $urandom; o.nd2 = $urandom;
        o.otype = 1'($urandom_range(1));
        return o;
    endfunction

    task automatic drive();
        if (p_rst > 0 && $urandom_range(999) < 32'(p_rst)) rst_cnt = 1;
        reset = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && p_new > 0 && $urandom_range(99) < 32'(p_new)) begin
                pend[i] = 1;
                rq[i] = rand_ops();
            end else if (pend[i] && p_drop > 0 && $urandom_range(99) < 32'(p_drop)) begin
                pend[i] = 0;
            end
            req_valid[i]          = pend[i];
            req_rate[i*W +: W]    = rq[i].rate;
            req_timetm[i*W +: W]  = rq[i].timetm;
            req_spot[i*W +: W]    = rq[i].spot;
            req_strike[i*W +: W]  = rq[i].strike;
            req_nd1[i*W +: W]     = rq[i].nd1;
            req_nd2[i*W +: W]     = rq[i].nd2;
            req_otype[i]          = rq[i].otype;
        end
        op_done  = (cyc == done_cyc);
        op_price = op_done ? stub_price : $urandom;
        // Stray completions only where the scheduler must ignore them.
        if (!op_done && p_stray > 0 && (!job || cyc >= exp_rsp) && $urandom_range(99) < 32'(p_stray))
            op_done = 1'b1;
        if (job && cyc < exp_rsp + hold_n) rsp_ready = 1'b0;
        else rsp_ready = ($urandom_range(99) < 32'(p_rdy));
    endtask

    task automatic monitor();
        int win, lat, to_cur, s;
        logic [N-1:0] exp_ready;
        bit st, rv;
        to_cur = sel ? TO_W : TO_A;
        if (reset) begin
            chk("ready_in_reset", 64'(m_req_ready), 0);
            job = 0; ptr = 0; post_rst = 1;
            return;
        end
        if (post_rst) begin
            chk("rst_busy", 64'(m_busy), 0);
            chk("rst_rsp_valid", 64'(m_rsp_valid), 0);
            chk("rst_op_start", 64'(m_op_start), 0);
            chk("rst_ops", 64'(m_op_rate | m_op_timetm | m_op_spot | m_op_strike | m_op_nd1 | m_op_nd2), 0);
            chk("rst_rsp", {m_rsp_price, 29'd0, m_rsp_id, m_op_otype}, 0);
            post_rst = 0;
        end
        win = -1;
        if (!job) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (win < 0 && req_valid[i]) win = i;
            end
        end
        exp_ready = (win >= 0) ? (4'd1 << win) : 4'd0;
        chk("req_ready", 64'(m_req_ready), 64'(exp_ready));
        chk("busy", 64'(m_busy), 64'(job));
        st = job && (cyc == acc_cyc + 1);
        chk("op_start", 64'(m_op_start), 64'(st));
        if (st) begin
            chk("op_rate", 64'(m_op_rate), 64'(job_ops.rate));
            chk("op_timetm", 64'(m_op_timetm), 64'(job_ops.timetm));
            chk("op_spot", 64'(m_op_spot), 64'(job_ops.spot));
            chk("op_strike", 64'(m_op_strike), 64'(job_ops.strike));
            chk("op_nd1", 64'(m_op_nd1), 64'(job_ops.nd1));
            chk("op_nd2", 64'(m_op_nd2), 64'(job_ops.nd2));
            chk("op_otype", 64'(m_op_otype), 64'(job_ops.otype));
        end
        rv = job && (cyc >= exp_rsp);
        chk("rsp_valid", 64'(m_rsp_valid), 64'(rv));
        if (rv) begin
            chk("rsp_id", 64'(m_rsp_id), 64'(job_id));
            chk("rsp_price", 64'(m_rsp_price), 64'(exp_price));
            chk("rsp_error", 64'(m_rsp_error), 64'(exp_err));
        end
        if (rv && rsp_ready) begin
            ptr = (job_id + 1) % N;
            job = 0;
            rsp_cnt++;
        end else if (win >= 0) begin
            job = 1; job_id = win; job_ops = rq[win]; pend[win] = 0; acc_cyc = cyc;
            grants.push_back(win);
            s = cyc + 1;
            lat = (lat_mode < 0) ? int'($urandom_range(1, to_cur + 4)) : lat_mode;
            stub_price = (price_mode == 1) ? W'(1000 + win) : (price_mode == 2) ? fixed_price : $urandom;
            done_cyc = (lat > 0) ? s + lat : -1;
            if (lat >= 1 && lat <= to_cur) begin
                exp_rsp = s + lat + 1; exp_err = 0; exp_price = stub_price;
            end else begin
                exp_rsp = s + to_cur + 1; exp_err = 1; exp_price = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_reqs();
        p_new = 0; p_drop = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
    endtask

    task automatic wait_rsp(input int target, input int max, input string tag);
        for (int k = 0; k < max && rsp_cnt < target; k++) step();
        chk(tag, 64'(rsp_cnt), 64'(target));
    endtask

    task automatic drain();
        clear_reqs();
        for (int k = 0; k < 200 && job; k++) step();
        step();
        chk("drain_busy", 64'(m_busy), 0);
    endtask

    initial begin
        int g0, r0;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin pend[i] = 0; rq[i] = '0; end

        // Reset, then a single call from requester 0 answered 20 cycles after op_start
        repeat (5) step();
        rq[0] = '{rate: 32'd3277, timetm: 32'd65536, spot: 32'd6553600, strike: 32'd6553600,
                  nd1: 32'd55166, nd2: 32'd10470, otype: 1'b0};
        pend[0] = 1; lat_mode = 20; price_mode = 2; fixed_price = 32'd4525000;
        r0 = rsp_cnt;
        wait_rsp(r0 + 1, 60, "single_done");
        chk("single_grant", 64'(grants[$]), 0);
        drain();

        // Round-robin with all requesters continuously valid
        rst_cnt = 2; step(); step();
        for (int i = 0; i < N; i++) begin pend[i] = 1; rq[i] = rand_ops(); end
        p_new = 100; lat_mode = -1; price_mode = 1;
        lat_mode = 5;
        g0 = grants.size();
        for (int k = 0; k < 200 && grants.size() < g0 + 5; k++) step();
        chk("rr_count", 64'(grants.size()), 64'(g0 + 5));
        for (int k = 0; k < 5 && g0 + k < grants.size(); k++)
            chk("rr_order", 64'(grants[g0 + k]), 64'(exp_order[k]));

        // Backpressure: rsp_ready low for 10 cycles with requests pending
        hold_n = 10;
        r0 = rsp_cnt;
        wait_rsp(r0 + 2, 120, "bp_done");
        hold_n = 0;
        drain();

        // Watchdog on the short-timeout instance, stray done after expiry
        sel = 1; rst_cnt = 2; step(); step();
        lat_mode = 0; p_stray = 40; price_mode = 0;
        pend[1] = 1; rq[1] = rand_ops();
        r0 = rsp_cnt;
        wait_rsp(r0 + 1, 60, "wd_done");
        repeat (10) step();
        chk("wd_single_rsp", 64'(rsp_cnt), 64'(r0 + 1));
        p_stray = 0;
        drain();

        // Reset mid-job, leftover op_done lands in IDLE
        sel = 0; rst_cnt = 2; step(); step();
        pend[0] = 1; rq[0] = rand_ops(); lat_mode = 40;
        for (int k = 0; k < 40 && !(job && cyc >= acc_cyc + 6); k++) step();
        chk("mid_in_wait", 64'(m_busy), 1);
        r0 = rsp_cnt;
        rst_cnt = 1;
        repeat (50) step();
        chk("mid_no_rsp", 64'(rsp_cnt), 64'(r0));
        pend[2] = 1; rq[2] = rand_ops(); lat_mode = 5;
        wait_rsp(r0 + 1, 40, "mid_fresh_done");
        chk("mid_fresh_grant", 64'(grants[$]), 2);
        drain();

        // Spurious op_done in IDLE, then a put from requester 3
        p_stray = 30;
        r0 = rsp_cnt;
        repeat (20) step();
        chk("spur_no_rsp", 64'(rsp_cnt), 64'(r0));
        p_stray = 0;
        rq[3] = rand_ops(); rq[3].otype = 1'b1; pend[3] = 1; lat_mode = 3;
        wait_rsp(r0 + 1, 40, "put_done");
        chk("put_grant", 64'(grants[$]), 3);
        drain();

        // Random traffic on both instances
        p_new = 30; p_drop = 5; p_rdy = 60; p_stray = 10; lat_mode = -1; price_mode = 0; p_rst = 2;
        repeat (3000) step();
        p_rst = 0; drain();
        sel = 1; rst_cnt = 2;
        p_new = 30; p_drop = 5; p_stray = 10; p_rst = 2;
        repeat (1500) step();
        p_rst = 0; drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/option_price_sched.md
Name: option_price_sched

Overview:
- Shares one Black-Scholes pricing datapath among NREQ requesters, each presenting a full operand set (rate, time to maturity, spot, strike, N(d1), N(d2), option type) in Q16.16.
- Arbitrates round-robin, latches the winner's operands and pulses the datapath's start (norm_done) input.
- Waits for completion with a watchdog, then returns the price tagged with the requester id.
- Sits between the CND/d1-d2 front end and the OptionPrice datapath.

Parameters:
- WIDTH, 32, operand and result width (Q16.16 signed)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester id width (>= clog2(NREQ))
- TIMEOUT, 4096, maximum cycles waited in WAIT before an error response

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_rate  in  NREQ*WIDTH  packed rates, requester i at bits [i*WIDTH +: WIDTH]
- req_timetm  in  NREQ*WIDTH  packed time to maturity
- req_spot  in  NREQ*WIDTH  packed spot
- req_strike  in  NREQ*WIDTH  packed strike
- req_nd1  in  NREQ*WIDTH  packed N(d1)
- req_nd2  in  NREQ*WIDTH  packed N(d2)
- req_otype  in  NREQ  0 = call, 1 = put
- op_rate, op_timetm, op_spot, op_strike, op_nd1, op_nd2  out  WIDTH each  latched operands to datapath
- op_otype  out  1  latched option type
- op_start  out  1  one-cycle start pulse, drives datapath norm_done
- op_done  in  1  datapath completion pulse
- op_price  in  WIDTH  datapath result, valid when op_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index of response
- rsp_price  out  WIDTH  returned price
- rsp_error  out  1  1 = watchdog expired, price forced to 0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, timer=0. All outputs 0: op_* registers, op_start, rsp_*, busy; req_ready is 0 while reset=1. Reset mid-job aborts the job with no response and no op_start.
- States are IDLE, START, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching from rr_ptr upward with wrap modulo NREQ.
  - req_ready[grant]=1 combinationally in that same cycle, only in IDLE and only for grant; the handshake completes that cycle.
  - At the edge, latch grant's operands into op_* and grant into rsp_id, then go to START.
  - No req_valid: stay in IDLE.
- START: op_start=1 for exactly this one cycle; timer<=0; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - op_done=1: rsp_price<=op_price, rsp_error<=0, go to RESP.
  - Otherwise, when timer==TIMEOUT-1: rsp_price<=0, rsp_error<=1, go to RESP.
  - op_done wins if it coincides with expiry.
- RESP:
  - rsp_valid=1; rsp_id, rsp_price and rsp_error are held stable until rsp_ready=1.
  - On the handshake cycle: rr_ptr<=(rsp_id+1) mod NREQ, go to IDLE.
  - The next grant is therefore possible one cycle after the response handshake.
- op_done outside WAIT (including in the START cycle) is ignored.
- op_* are held from the capture edge until the next grant. They are not cleared on return to IDLE.
- Latency: accept in cycle T, op_start high in T+1. If op_done arrives in cycle D, rsp_valid is high from D+1. Minimum accept-to-rsp_valid is 3 cycles, with op_done in T+2.
- Requests deasserted before being granted are simply not served; no internal request queue.
- No arithmetic on the data path; values pass through bit-exact. Timer width is clog2(TIMEOUT)+1.

Test Plan:
- Single call request: requester 0 presents rate=3277, timetm=65536, spot=6553600, strike=6553600, nd1=55166, nd2=10470, otype=0. Stub returns op_done with op_price=4525000 twenty cycles after op_start.
  - Required: req_ready[0] for 1 cycle; op_start for exactly 1 cycle with the op_* values above.
  - rsp_valid 1 cycle after op_done, with rsp_id=0, rsp_price=4525000, rsp_error=0.
- Round-robin fairness: all 4 requesters hold req_valid continuously and the stub returns op_price=1000+id.
  - Required: grant order 0,1,2,3,0.
  - Each response's rsp_price matches its rsp_id.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  - Required: rsp_* stable throughout; busy=1; req_ready stays 0 despite pending requests.
  - Next grant occurs 1 cycle after rsp_ready rises.
- Watchdog: stub never asserts op_done, with TIMEOUT=16.
  - Required: rsp_valid exactly 16 cycles after leaving START, with rsp_error=1 and rsp_price=0.
  - A stray op_done pulsed after expiry is ignored.
- Reset mid-job: assert reset for 1 cycle while in WAIT, then let the stub pulse op_done.
  - Required: no rsp_valid, busy=0, rr_ptr=0.
  - A fresh request from requester 2 is then served normally.
- Spurious op_done while in IDLE, followed by a put request (otype=1) from requester 3.
  - Required: no response to the spurious pulse.
  - The put request is served with op_otype=1 and rsp_id=3.
